// File: rtl/sign_convert_pipe_if.sv
// Handshake bundle for sign_convert_pipe: input beat channel and buffered result channel.
interface sign_convert_pipe_if #(
    parameter int unsigned WIDTH = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_neg;
    logic             out_ovf;
    logic             out_nz;

    // Producer/consumer side (drives beats, accepts results).
    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_neg, out_ovf, out_nz
    );

    // Converter side.
    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_neg, out_ovf, out_nz
    );
endinterface

// File: rtl/sign_convert_pipe.sv
// Sign-format converter with a 2-entry result buffer and saturating statistics counters.
module sign_convert_pipe #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    sign_convert_pipe_if.slave bus,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] neg_count,
    output logic [CNT_W-1:0] ovf_count
);

    typedef enum logic [1:0] {
        ModeMask  = 2'b00,
        ModeSm2tc = 2'b01,
        ModeTc2sm = 2'b10,
        ModeAbs   = 2'b11
    } mode_e;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             neg;
        logic             ovf;
        logic             nz;
    } entry_t;

    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MaxPos = {1'b0, {(WIDTH-1){1'b1}}};

    entry_t           conv;
    logic             sgn;
    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] neg_in;
    logic             is_min;
    logic             neg_zero;

    entry_t           mem_q [2];
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       count_q, count_d;
    logic             push, pop;
    logic [CNT_W-1:0] neg_cnt_q, neg_cnt_d;
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    // Combinational conversion of the offered beat into a buffer entry.
    always_comb begin
        sgn      = bus.in_data[WIDTH-1];
        mag      = {1'b0, bus.in_data[WIDTH-2:0]};
        neg_in   = '0 - bus.in_data;
        is_min   = (bus.in_data == MinVal);
        neg_zero = sgn & (bus.in_data[WIDTH-2:0] == '0);
        conv     = '0;
        conv.neg = sgn;
        unique case (mode_e'(bus.in_mode))
            ModeMask: begin
                conv.data = mag;
                conv.nz   = neg_zero;
            end
            ModeSm2tc: begin
                // Negative zero maps to 0 naturally since -0 == 0.
                conv.data = sgn ? ('0 - mag) : mag;
                conv.nz   = neg_zero;
            end
            ModeTc2sm: begin
                if (!sgn) begin
                    conv.data = bus.in_data;
                end else if (is_min) begin
                    conv.data = '1;
                    conv.ovf  = 1'b1;
                end else begin
                    conv.data = {1'b1, neg_in[WIDTH-2:0]};
                end
            end
            ModeAbs: begin
                if (!sgn) begin
                    conv.data = bus.in_data;
                end else if (is_min) begin
                    conv.data = MaxPos;
                    conv.ovf  = 1'b1;
                end else begin
                    conv.data = neg_in;
                end
            end
            default: conv = '0;
        endcase
    end

    // Buffer handshake; in_ready depends only on registered occupancy.
    always_comb begin
        bus.in_ready  = (count_q != 2'd2);
        bus.out_valid = (count_q != 2'd0);
        push          = bus.in_valid & bus.in_ready;
        pop           = bus.out_valid & bus.out_ready;
        count_d       = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
        bus.out_data = mem_q[rd_ptr_q].data;
        bus.out_neg  = mem_q[rd_ptr_q].neg;
        bus.out_ovf  = mem_q[rd_ptr_q].ovf;
        bus.out_nz   = mem_q[rd_ptr_q].nz;
    end

    // Saturating counters; clear takes priority over a same-cycle increment.
    always_comb begin
        neg_cnt_d = neg_cnt_q;
        ovf_cnt_d = ovf_cnt_q;
        if (cnt_clr) begin
            neg_cnt_d = '0;
            ovf_cnt_d = '0;
        end else begin
            if (push && conv.neg && (neg_cnt_q != '1)) begin
                neg_cnt_d = neg_cnt_q + 1'b1;
            end
            if (push && conv.ovf && (ovf_cnt_q != '1)) begin
                ovf_cnt_d = ovf_cnt_q + 1'b1;
            end
        end
    end

    // Buffer storage, pointers, occupancy and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0]  <= '0;
            mem_q[1]  <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            neg_cnt_q <= '0;
            ovf_cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= conv;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q   <= count_d;
            neg_cnt_q <= neg_cnt_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign neg_count = neg_cnt_q;
    assign ovf_count = ovf_cnt_q;

endmodule

// File: tb/tb_sign_convert_pipe.sv
// Bench for sign_convert_pipe: directed literal checks plus randomized traffic against a queue model.
module tb_sign_convert_pipe;

    localparam int W  = 4;
    localparam int CW = 2;

    typedef struct {
        int data;
        int neg;
        int ovf;
        int nz;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cnt_clr;
    logic [CW-1:0] neg_count;
    logic [CW-1:0] ovf_count;

    sign_convert_pipe_if #(.WIDTH(W)) bus ();

    sign_convert_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .cnt_clr   (cnt_clr),
        .neg_count (neg_count),
        .ovf_count (ovf_count)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   m_neg = 0;
    int   m_ovf = 0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference conversion from the numeric meaning of each format.
    function automatic exp_t model_conv(input int d, input int mode);
        exp_t e;
        int full = 1 << W;
        int half = 1 << (W - 1);
        int s    = (d >= half) ? 1 : 0;
        int mag  = d % half;
        int v    = s ? d - full : d;
        e.neg = s;
        e.ovf = 0;
        e.nz  = 0;
        e.data = 0;
        case (mode)
            0: begin e.data = mag; e.nz = (s && mag == 0) ? 1 : 0; end
            1: begin e.data = s ? (full - mag) % full : mag; e.nz = (s && mag == 0) ? 1 : 0; end
            2: begin
                if (v >= 0) e.data = v;
                else if (-v <= half - 1) e.data = half + (-v);
                else begin e.data = full - 1; e.ovf = 1; end
            end
            default: begin
                if (v >= 0) e.data = v;
                else if (-v <= half - 1) e.data = -v;
                else begin e.data = half - 1; e.ovf = 1; end
            end
        endcase
        return e;
    endfunction

    task automatic model_update();
        bit   do_push, do_pop;
        exp_t e;
        int   maxc = (1 << CW) - 1;
        if (!rst_n) begin
            q.delete();
            m_neg = 0;
            m_ovf = 0;
        end else begin
            do_push = bus.in_valid && (q.size() < 2);
            do_pop  = (q.size() > 0) && bus.out_ready;
            e = model_conv(int'(bus.in_data), int'(bus.in_mode));
            if (cnt_clr) begin
                m_neg = 0;
                m_ovf = 0;
            end else if (do_push) begin
                if (e.neg == 1 && m_neg < maxc) m_neg++;
                if (e.ovf == 1 && m_ovf < maxc) m_ovf++;
            end
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(e);
        end
    endtask

    task automatic compare();
        chk("in_ready", int'(bus.in_ready), (q.size() < 2) ? 1 : 0);
        chk("out_valid", int'(bus.out_valid), (q.size() != 0) ? 1 : 0);
        if (q.size() != 0) begin
            chk("out_data", int'(bus.out_data), q[0].data);
            chk("out_neg", int'(bus.out_neg), q[0].neg);
            chk("out_ovf", int'(bus.out_ovf), q[0].ovf);
            chk("out_nz", int'(bus.out_nz), q[0].nz);
        end
        chk("neg_count", int'(neg_count), m_neg);
        chk("ovf_count", int'(ovf_count), m_ovf);
    endtask

    // Inputs are set at the falling edge; one call covers a full clock period.
    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic drive(input bit v, input int d, input int mode, input bit rdy);
        bus.in_valid  = v;
        bus.in_data   = W'(d);
        bus.in_mode   = 2'(mode);
        bus.out_ready = rdy;
    endtask

    initial begin
        rst_n   = 1'b0;
        cnt_clr = 1'b0;
        drive(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_neg_count", int'(neg_count), 0);
        rst_n = 1'b1;
        cycle();
        chk("rst_in_ready", int'(bus.in_ready), 1);

        // Model pinning with hand-computed results.
        drive(1, 4'b1011, 0, 1); cycle();
        chk("mask_1011", int'(bus.out_data), 4'b0011);
        drive(1, 4'b1011, 1, 1); cycle();
        chk("sm2tc_1011", int'(bus.out_data), 4'b1101);
        drive(1, 4'b1000, 1, 1); cycle();
        chk("sm2tc_negzero", int'(bus.out_data), 0);
        chk("sm2tc_nz", int'(bus.out_nz), 1);
        drive(1, 4'b1101, 2, 1); cycle();
        chk("tc2sm_1101", int'(bus.out_data), 4'b1011);

        // Saturation cases with fresh counters.
        drive(0, 0, 0, 1); cnt_clr = 1'b1; cycle(); cnt_clr = 1'b0;
        drive(1, 4'b1000, 2, 1); cycle();
        chk("tc2sm_min", int'(bus.out_data), 4'b1111);
        chk("tc2sm_min_ovf", int'(bus.out_ovf), 1);
        drive(1, 4'b1000, 3, 1); cycle();
        chk("abs_min", int'(bus.out_data), 4'b0111);
        chk("abs_min_ovf", int'(bus.out_ovf), 1);
        drive(1, 4'b1101, 3, 1); cycle();
        chk("abs_1101", int'(bus.out_data), 4'b0011);
        chk("abs_1101_ovf", int'(bus.out_ovf), 0);
        drive(0, 0, 0, 1); cycle();
        chk("sat_ovf_count", int'(ovf_count), 2);
        chk("sat_neg_count", int'(neg_count), 3);

        // Backpressure: A, B fill the buffer, C must wait.
        drive(1, 4'b0001, 0, 0); cycle();
        drive(1, 4'b0010, 0, 0); cycle();
        drive(1, 4'b0011, 0, 0); cycle();
        chk("bp_full_ready", int'(bus.in_ready), 0);
        chk("bp_head_a", int'(bus.out_data), 4'b0001);
        drive(1, 4'b0011, 0, 1); cycle();
        chk("bp_head_b", int'(bus.out_data), 4'b0010);
        cycle();
        chk("bp_head_c", int'(bus.out_data), 4'b0011);
        drive(0, 0, 0, 1); cycle();
        chk("bp_drained", int'(bus.out_valid), 0);

        // Steady push+pop at occupancy 1.
        drive(1, $urandom_range(15), $urandom_range(3), 0); cycle();
        for (int i = 0; i < 10; i++) begin
            drive(1, $urandom_range(15), $urandom_range(3), 1); cycle();
            chk("steady_valid", int'(bus.out_valid), 1);
            chk("steady_ready", int'(bus.in_ready), 1);
        end
        drive(0, 0, 0, 1); cycle();

        // Counter saturation and clear priority.
        cnt_clr = 1'b1; cycle(); cnt_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 8 + i, 0, 1); cycle();
        end
        chk("neg_sat", int'(neg_count), 3);
        drive(1, 4'b1001, 0, 1); cnt_clr = 1'b1; cycle(); cnt_clr = 1'b0;
        chk("neg_clr_wins", int'(neg_count), 0);

        // Asynchronous reset with a full buffer and nonzero counters.
        drive(1, 4'b1110, 3, 0); cycle();
        drive(1, 4'b1100, 3, 0); cycle();
        drive(0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", int'(bus.out_valid), 0);
        chk("arst_out_data", int'(bus.out_data), 0);
        chk("arst_out_neg", int'(bus.out_neg), 0);
        chk("arst_neg_count", int'(neg_count), 0);
        q.delete(); m_neg = 0; m_ovf = 0;
        @(negedge clk);
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("arst_in_ready", int'(bus.in_ready), 1);
        drive(1, 4'b1010, 3, 1); cycle();
        chk("arst_first_valid", int'(bus.out_valid), 1);
        chk("arst_first_data", int'(bus.out_data), 4'b0110);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(3) != 0, $urandom_range(15), $urandom_range(3),
                  $urandom_range(2) != 0);
            cnt_clr = ($urandom_range(15) == 0);
            cycle();
        end
        cnt_clr = 1'b0;
        drive(0, 0, 0, 1);
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sign_convert_pipe.md
# sign_convert_pipe

Parametrised, handshaked sign-format converter for the calculator datapath. It accepts a WIDTH-bit operand with a per-beat mode and performs one of four conversions: strip sign, sign-magnitude to two's complement, two's complement to sign-magnitude, or saturating absolute value. Results pass through a 2-entry output buffer with valid/ready flow control. Saturating statistics counters record negative inputs and overflow events for the display/debug path.

## Interface
- WIDTH, 4, operand/result width in bits (>= 2)
- CNT_W, 8, width of each statistics counter

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_data  in  WIDTH  operand
- in_mode  in  2  00 MASK, 01 SM2TC, 10 TC2SM, 11 ABS
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes head this cycle
- out_data  out  WIDTH  converted result
- out_neg  out  1  sign bit of the originating input
- out_ovf  out  1  result saturated (not representable)
- out_nz  out  1  input was negative zero (sign-magnitude modes)
- cnt_clr  in  1  synchronous clear of both counters
- neg_count  out  CNT_W  accepted beats with in_data[WIDTH-1]=1
- ovf_count  out  CNT_W  accepted beats producing out_ovf=1

## Operation
- s = in_data[WIDTH-1], m = in_data[WIDTH-2:0], MIN = 1 followed by WIDTH-1 zeros.
- MASK: y = {0,m}; nz = s & (m==0); ovf = 0.
- SM2TC: y = s ? (2^WIDTH - {0,m}) mod 2^WIDTH : {0,m}; negative zero gives y = 0, nz = 1; ovf = 0.
- TC2SM: s=0 -> y = in_data; s=1 and in_data != MIN -> y = {1, (-in_data)[WIDTH-2:0]}; in_data == MIN -> y = {1, all ones}, ovf = 1; nz = 0.
- ABS: s=0 -> y = in_data; s=1 and != MIN -> y = -in_data; MIN -> y = {0, all ones}, ovf = 1; nz = 0.
- Conversion is combinational on input; result, flags stored together as one buffer entry.
- Buffer: 2-entry FIFO, occupancy 0..2. in_ready = (occupancy < 2), registered-state only, no combinational path from out_ready.
- Push when in_valid & in_ready; pop when out_valid & out_ready; simultaneous push and pop keeps occupancy unchanged, order preserved.
- out_valid = (occupancy != 0); out_data/out_neg/out_ovf/out_nz show head entry, held stable while out_valid & !out_ready.
- Counters increment on push only, saturate at 2^CNT_W-1 (no wrap). cnt_clr wins over same-cycle increment (that beat not counted). Buffer unaffected by cnt_clr.

## Timing
- Latency: beat pushed at edge k is visible with out_valid=1 after edge k (1 cycle) when buffer empty.
- Throughput: 1 beat/cycle with out_ready held high.
- Occupancy 2, out_ready=1: in_ready still 0 that cycle; rises the cycle after the pop.
- Counters reflect a push one cycle after the accepting edge.
- Reset (asserted anytime, including mid-transfer): occupancy 0, in_ready=1 after release, out_valid=0, out_data=0, out_neg=0, out_ovf=0, out_nz=0, neg_count=0, ovf_count=0; buffered beats discarded.

## Test plan
- WIDTH=4, out_ready=1: MASK 1011 -> 0011; SM2TC 1011 -> 1101; SM2TC 1000 -> 0000 nz=1; TC2SM 1101 -> 1011; each one cycle after acceptance.
- Saturation: TC2SM 1000 -> 1111 ovf=1; ABS 1000 -> 0111 ovf=1; ABS 1101 -> 0011 ovf=0; ovf_count=2, neg_count=3.
- Backpressure: out_ready=0, offer 3 beats A,B,C -> in_ready low after A,B accepted, out_data=A stable; raise out_ready -> A, B, C emerge in order, no loss/duplication.
- Simultaneous push/pop at occupancy 1 for 10 cycles -> occupancy stays 1, every beat delivered exactly once.
- CNT_W=2: 5 negative beats -> neg_count stops at 3; cnt_clr with concurrent negative beat -> neg_count=0 next cycle.
- Assert rst_n low with occupancy 2 and counters nonzero -> all outputs zero immediately, in_ready=1 after release, first new beat out after 1 cycle.
